sn_stream_gen: RTL

SN_STREAM_GEN -- requirements
Module: sn_stream_gen

---
 rtl/sn_stream_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sn_stream_gen.sv
// sn_stream_gen: parallel bipolar stochastic-number stream generator.
// Each lane turns a 4-bit signed value into a bitstream whose ones density over
// every 16-cycle period equals (x+8)/16. Lanes use rotated bit-reversed
// counters so that they stay decorrelated.
module sn_stream_gen #(
    parameter int unsigned LANES = 4,
    parameter int unsigned PW    = 3
) (
    input  logic                  i_clk_ssg,
    input  logic                  i_rst_n_ssg,
    input  logic                  i_start_ssg,
    input  logic [LANES-1:0][3:0] i_x_ssg,
    input  logic [PW-1:0]         i_per_ssg,
    input  logic                  i_stall_ssg,
    input  logic                  i_abort_ssg,
    output logic [LANES-1:0]      o_sn_bit_ssg,
    output logic                  o_valid_ssg,
    output logic                  o_busy_ssg,
    output logic                  o_done_ssg
);

    localparam int unsigned TW = 4 + PW;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } state_e;

    state_e                r_state;
    logic [LANES-1:0][3:0] r_x;
    logic [PW-1:0]         r_per;
    logic [TW-1:0]         r_t;

    logic [TW-1:0]         w_t_last;
    logic [TW-1:0]         w_t_next;
    logic [LANES-1:0]      w_bits_start;
    logic [LANES-1:0]      w_bits_next;

    // Compare each lane's offset-binary value against its bit-reversed counter.
    function automatic logic [LANES-1:0] sn_bits(input logic [LANES-1:0][3:0] x,
                                                 input logic [3:0] c);
        logic [LANES-1:0] bits;
        logic [3:0]       u;
        logic [3:0]       off;
        logic [3:0]       s;
        logic [3:0]       r;
        bits = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            u       = {~x[k][3], x[k][2:0]};
            off     = 4'((k % 4) * 4);
            s       = c + off;
            r       = {s[0], s[1], s[2], s[3]};
            bits[k] = (r < u);
        end
        return bits;
    endfunction

    // Index of the final bit: 16*(P+1)-1 is simply P followed by four ones.
    always_comb begin
        w_t_last     = {r_per, 4'hF};
        w_t_next     = r_t + 1'b1;
        w_bits_start = sn_bits(i_x_ssg, 4'd0);
        w_bits_next  = sn_bits(r_x, w_t_next[3:0]);
    end

    // FSM with registered outputs; r_t is the index of the bit currently presented.
    always_ff @(posedge i_clk_ssg or negedge i_rst_n_ssg) begin
        if (!i_rst_n_ssg) begin
            r_state      <= StIdle;
            r_x          <= '0;
            r_per        <= '0;
            r_t          <= '0;
            o_sn_bit_ssg <= '0;
            o_valid_ssg  <= 1'b0;
            o_busy_ssg   <= 1'b0;
            o_done_ssg   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    o_valid_ssg <= 1'b0;
                    o_done_ssg  <= 1'b0;
                    // Abort is ignored here, so start wins when both are high.
                    if (i_start_ssg) begin
                        r_x          <= i_x_ssg;
                        r_per        <= i_per_ssg;
                        r_t          <= '0;
                        r_state      <= StStream;
                        o_busy_ssg   <= 1'b1;
                        o_valid_ssg  <= 1'b1;
                        o_sn_bit_ssg <= w_bits_start;
                    end
                end
                StStream: begin
                    if (i_abort_ssg) begin
                        r_state      <= StIdle;
                        o_busy_ssg   <= 1'b0;
                        o_valid_ssg  <= 1'b0;
                        o_done_ssg   <= 1'b0;
                        o_sn_bit_ssg <= '0;
                    end else if (i_stall_ssg) begin
                        o_valid_ssg <= 1'b0;
                    end else if (r_t == w_t_last) begin
                        r_state      <= StDone;
                        o_valid_ssg  <= 1'b0;
                        o_done_ssg   <= 1'b1;
                        o_sn_bit_ssg <= '0;
                    end else begin
                        r_t          <= w_t_next;
                        o_valid_ssg  <= 1'b1;
                        o_sn_bit_ssg <= w_bits_next;
                    end
                end
                StDone: begin
                    r_state     <= StIdle;
                    o_busy_ssg  <= 1'b0;
                    o_valid_ssg <= 1'b0;
                    o_done_ssg  <= 1'b0;
                end
                default: begin
                    r_state     <= StIdle;
                    o_busy_ssg  <= 1'b0;
                    o_valid_ssg <= 1'b0;
                    o_done_ssg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
